// File: rtl/sp_array_rmw_ctrl.sv
// sp_array_rmw_ctrl
//   Initiator-side controller for a single-port flip-flop array with a
//   csb0/web0/addr0/din0/dout0 port (active-low selects, one-cycle
//   registered read). Accepts READ / WRITE / SET / CLR / FLUSH requests,
//   sequences them onto the array and returns one response pulse per request.
//
// Ports
//   clk0, rst0               clock, synchronous active-high reset
//   req_valid / req_ready    request handshake
//   req_op, req_addr,        request fields (op 00 RD, 01 WR, 10 SET, 11 CLR)
//   req_wdata, req_flush     wdata is data for WRITE, mask for SET/CLR
//   resp_valid, resp_rdata   one-cycle response pulse, no backpressure
//   arr_csb0, arr_web0,      array port drive (active-low selects)
//   arr_addr0, arr_din0
//   arr_dout0                array read data, valid the cycle after a read
//
// Handshake: a request transfers on a rising clk0 edge where req_valid and
// req_ready are both 1. req_valid must stay high, with stable fields, until
// that edge. req_ready depends only on state and rst0, never on req_valid.
// resp_valid is a single-cycle pulse the receiver must take when it appears.
module sp_array_rmw_ctrl #(
  parameter int S_INDEX = 4,
  parameter int WIDTH   = 1
) (
  input  logic               clk0,
  input  logic               rst0,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [1:0]         req_op,
  input  logic [S_INDEX-1:0] req_addr,
  input  logic [WIDTH-1:0]   req_wdata,
  input  logic               req_flush,
  output logic               resp_valid,
  output logic [WIDTH-1:0]   resp_rdata,
  output logic               arr_csb0,
  output logic               arr_web0,
  output logic [S_INDEX-1:0] arr_addr0,
  output logic [WIDTH-1:0]   arr_din0,
  input  logic [WIDTH-1:0]   arr_dout0
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_RESP = 3'd1,
    ST_WR_RESP = 3'd2,
    ST_RMW     = 3'd3,
    ST_FLUSH   = 3'd4
  } state_t;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;

  state_t             state_q, state_d;
  logic [S_INDEX-1:0] cnt_q, cnt_d;
  logic [S_INDEX-1:0] addr_q, addr_d;
  logic [WIDTH-1:0]   mask_q, mask_d;
  logic               set_q, set_d;

  logic               accept;
  logic [WIDTH-1:0]   rmw_new;

  assign accept  = req_valid & req_ready;
  assign rmw_new = set_q ? (arr_dout0 | mask_q) : (arr_dout0 & ~mask_q);

  // State register
  always_ff @(posedge clk0) begin
    if (rst0) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      mask_q  <= '0;
      set_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      mask_q  <= mask_d;
      set_q   <= set_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    mask_d  = mask_q;
    set_d   = set_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (req_flush) begin
            cnt_d   = '0;
            state_d = ST_FLUSH;
          end else begin
            case (req_op)
              OP_READ:  state_d = ST_RD_RESP;
              OP_WRITE: state_d = ST_WR_RESP;
              default: begin
                // SET (10) / CLR (11): op[0] low selects SET
                addr_d  = req_addr;
                mask_d  = req_wdata;
                set_d   = ~req_op[0];
                state_d = ST_RMW;
              end
            endcase
          end
        end
      end
      ST_RD_RESP, ST_WR_RESP, ST_RMW: state_d = ST_IDLE;
      ST_FLUSH: begin
        cnt_d = cnt_q + 1'b1;  // wraps to 0 after the last set
        if (&cnt_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic; everything is forced quiet while rst0 is high
  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = '0;
    arr_csb0   = 1'b1;
    arr_web0   = 1'b1;
    arr_addr0  = '0;
    arr_din0   = '0;
    if (!rst0) begin
      case (state_q)
        ST_IDLE: begin
          req_ready = 1'b1;
          // FLUSH issues nothing in its accept cycle
          if (req_valid && !req_flush) begin
            arr_csb0  = 1'b0;
            arr_addr0 = req_addr;
            if (req_op == OP_WRITE) begin
              arr_web0 = 1'b0;
              arr_din0 = req_wdata;
            end
          end
        end
        ST_RD_RESP: begin
          resp_valid = 1'b1;
          resp_rdata = arr_dout0;
        end
        ST_WR_RESP: begin
          resp_valid = 1'b1;
        end
        ST_RMW: begin
          arr_csb0   = 1'b0;
          arr_web0   = 1'b0;
          arr_addr0  = addr_q;
          arr_din0   = rmw_new;
          resp_valid = 1'b1;
          resp_rdata = arr_dout0;
        end
        ST_FLUSH: begin
          arr_csb0   = 1'b0;
          arr_web0   = 1'b0;
          arr_addr0  = cnt_q;
          resp_valid = &cnt_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sp_array_rmw_ctrl.sv
// tb_sp_array_rmw_ctrl
//   Directed bench for sp_array_rmw_ctrl (S_INDEX=4, WIDTH=8) driving a
//   behavioural single-port array that is cleared by the shared rst0.
module tb_sp_array_rmw_ctrl;

  localparam int S_INDEX = 4;
  localparam int WIDTH   = 8;

  // ---------------- clock / reset ----------------
  logic clk0 = 1'b0;
  logic rst0 = 1'b1;
  always #5 clk0 = ~clk0;

  logic               req_valid = 1'b0;
  logic               req_ready;
  logic [1:0]         req_op    = 2'b00;
  logic [S_INDEX-1:0] req_addr  = '0;
  logic [WIDTH-1:0]   req_wdata = '0;
  logic               req_flush = 1'b0;
  logic               resp_valid;
  logic [WIDTH-1:0]   resp_rdata;
  logic               arr_csb0;
  logic               arr_web0;
  logic [S_INDEX-1:0] arr_addr0;
  logic [WIDTH-1:0]   arr_din0;
  logic [WIDTH-1:0]   arr_dout0;

  int total = 0;
  int bad   = 0;

  sp_array_rmw_ctrl #(.S_INDEX(S_INDEX), .WIDTH(WIDTH)) dut (
    .clk0       (clk0),
    .rst0       (rst0),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_flush  (req_flush),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .arr_csb0   (arr_csb0),
    .arr_web0   (arr_web0),
    .arr_addr0  (arr_addr0),
    .arr_din0   (arr_din0),
    .arr_dout0  (arr_dout0)
  );

  // ---------------- array model ----------------
  logic [WIDTH-1:0] mem [2**S_INDEX];
  logic [WIDTH-1:0] dout_r;
  assign arr_dout0 = dout_r;

  always @(posedge clk0) begin
    if (rst0) begin
      for (int i = 0; i < 2**S_INDEX; i++) mem[i] <= '0;
      dout_r <= '0;
    end else if (!arr_csb0) begin
      if (!arr_web0) mem[arr_addr0] <= arr_din0;
      else           dout_r <= mem[arr_addr0];
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called at a negedge with the controller idle; returns at negedge+1
  // with the controller idle again.
  task automatic op_rt(input string tag, input logic [1:0] op, input logic [3:0] a,
                       input logic [7:0] wd, input logic [7:0] exp_rd);
    logic [7:0] exp_new;
    exp_new = (op == 2'b10) ? (exp_rd | wd) : (exp_rd & ~wd);
    req_valid = 1'b1; req_flush = 1'b0; req_op = op; req_addr = a; req_wdata = wd;
    #1;
    chk({tag, ".ready"}, 32'(req_ready), 32'd1);
    chk({tag, ".csb"},   32'(arr_csb0),  32'd0);
    chk({tag, ".web"},   32'(arr_web0),  (op == 2'b01) ? 32'd0 : 32'd1);
    chk({tag, ".addr"},  32'(arr_addr0), 32'(a));
    if (op == 2'b01) chk({tag, ".din"}, 32'(arr_din0), 32'(wd));
    @(posedge clk0); @(negedge clk0);
    req_valid = 1'b0;
    #1;
    chk({tag, ".resp"},  32'(resp_valid), 32'd1);
    chk({tag, ".rdata"}, 32'(resp_rdata), 32'(exp_rd));
    chk({tag, ".busy"},  32'(req_ready),  32'd0);
    chk({tag, ".csb1"},  32'(arr_csb0),   op[1] ? 32'd0 : 32'd1);
    if (op[1]) begin
      chk({tag, ".web1"},  32'(arr_web0),  32'd0);
      chk({tag, ".addr1"}, 32'(arr_addr0), 32'(a));
      chk({tag, ".din1"},  32'(arr_din0),  32'(exp_new));
    end
    @(posedge clk0); @(negedge clk0);
    #1;
    chk({tag, ".resp_end"},  32'(resp_valid), 32'd0);
    chk({tag, ".ready_end"}, 32'(req_ready),  32'd1);
  endtask

  // FLUSH from idle; optionally keeps a READ of set 4 pending throughout,
  // which is left driven (and about to be accepted) on return.
  task automatic flush_run(input string tag, input logic hold_read);
    req_valid = 1'b1; req_flush = 1'b1; req_op = 2'b01; req_addr = 4'd9;
    #1;
    chk({tag, ".ready"}, 32'(req_ready), 32'd1);
    chk({tag, ".csb"},   32'(arr_csb0),  32'd1);
    @(posedge clk0); @(negedge clk0);
    req_flush = 1'b0;
    if (hold_read) begin
      req_valid = 1'b1; req_op = 2'b00; req_addr = 4'd4;
    end else begin
      req_valid = 1'b0;
    end
    for (int i = 0; i < 16; i++) begin
      #1;
      chk({tag, ".csb"},   32'(arr_csb0),   32'd0);
      chk({tag, ".web"},   32'(arr_web0),   32'd0);
      chk({tag, ".addr"},  32'(arr_addr0),  32'(i));
      chk({tag, ".din"},   32'(arr_din0),   32'd0);
      chk({tag, ".resp"},  32'(resp_valid), (i == 15) ? 32'd1 : 32'd0);
      chk({tag, ".rdata"}, 32'(resp_rdata), 32'd0);
      chk({tag, ".busy"},  32'(req_ready),  32'd0);
      @(posedge clk0); @(negedge clk0);
    end
    #1;
    chk({tag, ".resp_end"},  32'(resp_valid), 32'd0);
    chk({tag, ".ready_end"}, 32'(req_ready),  32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int pulses;
    // reset, with a request presented that must be ignored
    @(negedge clk0);
    req_valid = 1'b1; req_op = 2'b01; req_addr = 4'd6; req_wdata = 8'h55;
    #1;
    chk("rst.ready", 32'(req_ready),  32'd0);
    chk("rst.resp",  32'(resp_valid), 32'd0);
    chk("rst.rdata", 32'(resp_rdata), 32'd0);
    chk("rst.csb",   32'(arr_csb0),   32'd1);
    chk("rst.web",   32'(arr_web0),   32'd1);
    chk("rst.addr",  32'(arr_addr0),  32'd0);
    chk("rst.din",   32'(arr_din0),   32'd0);
    @(posedge clk0); @(negedge clk0);
    req_valid = 1'b0;
    @(posedge clk0); @(negedge clk0);
    rst0 = 1'b0;
    #1;
    chk("post_rst.ready", 32'(req_ready), 32'd1);
    chk("post_rst.csb",   32'(arr_csb0),  32'd1);

    // basic read / write
    op_rt("rd3",  2'b00, 4'd3, 8'h00, 8'h00);
    op_rt("wr5",  2'b01, 4'd5, 8'hA5, 8'h00);
    op_rt("rd5",  2'b00, 4'd5, 8'h00, 8'hA5);

    // read-modify-write chain on set 5
    op_rt("set5", 2'b10, 4'd5, 8'h0F, 8'hA5);
    op_rt("clr5", 2'b11, 4'd5, 8'h81, 8'hAF);
    op_rt("rd5b", 2'b00, 4'd5, 8'h00, 8'h2E);

    // READ held while a SET is in its RMW cycle
    op_rt("wr2", 2'b01, 4'd2, 8'h10, 8'h00);
    req_valid = 1'b1; req_op = 2'b10; req_addr = 4'd2; req_wdata = 8'h01;
    #1;
    chk("hold_rmw.ready", 32'(req_ready), 32'd1);
    @(posedge clk0); @(negedge clk0);
    req_op = 2'b00; req_addr = 4'd2; req_wdata = 8'h00;
    #1;
    chk("hold_rmw.busy",  32'(req_ready),  32'd0);
    chk("hold_rmw.resp",  32'(resp_valid), 32'd1);
    chk("hold_rmw.rdata", 32'(resp_rdata), 32'h10);
    @(posedge clk0); @(negedge clk0);
    #1;
    chk("hold_rmw.ready2", 32'(req_ready),  32'd1);
    chk("hold_rmw.noresp", 32'(resp_valid), 32'd0);
    chk("hold_rmw.rdcsb",  32'(arr_csb0),   32'd0);
    @(posedge clk0); @(negedge clk0);
    req_valid = 1'b0;
    #1;
    chk("hold_rmw.rd_resp",  32'(resp_valid), 32'd1);
    chk("hold_rmw.rd_rdata", 32'(resp_rdata), 32'h11);
    @(posedge clk0); @(negedge clk0);

    // fill, flush, verify
    for (int i = 0; i < 16; i++) op_rt("fill", 2'b01, 4'(i), 8'hFF, 8'h00);
    op_rt("rd9_full", 2'b00, 4'd9, 8'h00, 8'hFF);
    flush_run("flush", 1'b0);
    for (int i = 0; i < 16; i++) op_rt("rd_flushed", 2'b00, 4'(i), 8'h00, 8'h00);

    // second flush (counter restarts from 0) with a READ held pending
    op_rt("wr4", 2'b01, 4'd4, 8'h3C, 8'h00);
    flush_run("flush_hold", 1'b1);
    @(posedge clk0); @(negedge clk0);
    req_valid = 1'b0;
    #1;
    chk("flush_hold.rd_resp",  32'(resp_valid), 32'd1);
    chk("flush_hold.rd_rdata", 32'(resp_rdata), 32'h00);
    @(posedge clk0); @(negedge clk0);

    // reset during FLUSH while the counter is at 7
    for (int i = 0; i < 16; i++) op_rt("fill2", 2'b01, 4'(i), 8'hFF, 8'h00);
    req_valid = 1'b1; req_flush = 1'b1;
    @(posedge clk0); @(negedge clk0);
    req_valid = 1'b0; req_flush = 1'b0;
    for (int i = 0; i < 7; i++) begin
      @(posedge clk0); @(negedge clk0);
    end
    #1;
    chk("rst_mid.addr7", 32'(arr_addr0), 32'd7);
    rst0 = 1'b1;
    #1;
    chk("rst_mid.csb",   32'(arr_csb0),   32'd1);
    chk("rst_mid.resp",  32'(resp_valid), 32'd0);
    chk("rst_mid.ready", 32'(req_ready),  32'd0);
    @(posedge clk0); @(negedge clk0);
    rst0 = 1'b0;
    #1;
    chk("rst_mid.ready_after", 32'(req_ready),  32'd1);
    chk("rst_mid.csb_after",   32'(arr_csb0),   32'd1);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      if (resp_valid || !arr_csb0) pulses++;
      @(posedge clk0); @(negedge clk0);
      #1;
    end
    chk("rst_mid.quiet", 32'(pulses), 32'd0);
    for (int i = 0; i < 16; i++) op_rt("rd_after_rst", 2'b00, 4'(i), 8'h00, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // overall time bound
  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "simulation time limit reached");
  end

endmodule
